tile_hit_judge: RTL

//  Producer of the score 'increment' strobe. Judges player KEY presses against the tile in the hit zone.

---
 rtl/tile_hit_judge.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/tile_hit_judge.sv
// Judges debounced key presses against the tile in the hit zone, emitting score and miss strobes.
// Build option: define JUDGE_DEBOUNCE_EN to enable the per-lane key debounce counters.
module tile_hit_judge #(
  parameter int LANES           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int WINDOW_CYCLES   = 12500000,
  parameter int MISS_LIMIT      = 3
) (
  input  logic                            clock,
  input  logic                            resetn,
  input  logic                            startn,
  input  logic [LANES-1:0]                keys,
  input  logic                            tile_arrive,
  input  logic [LANES-1:0]                tile_lane,
  output logic                            increment,
  output logic                            miss,
  output logic [$clog2(MISS_LIMIT+1)-1:0] miss_count,
  output logic                            game_over,
  output logic [LANES-1:0]                lane_led
);
  localparam int MCW = $clog2(MISS_LIMIT + 1);
  localparam int WCW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [MCW-1:0] LIMIT    = MCW'(MISS_LIMIT);
  localparam logic [WCW-1:0] WIN_LOAD = WCW'(WINDOW_CYCLES - 1);
`ifdef JUDGE_DEBOUNCE_EN
  localparam int DCW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [DCW-1:0] DB_LAST = DCW'(DEBOUNCE_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_TILE, S_WINDOW, S_HOLD, S_OVER
  } state_e;

  logic [LANES-1:0] sync1_q, sync2_q;
  logic [LANES-1:0] pressed, pressed_prev_q, press_p, rel_p;

  // Keys idle high, so synchronisers reset to the released level.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_q        <= '1;
      sync2_q        <= '1;
      pressed_prev_q <= '0;
    end else begin
      sync1_q        <= keys;
      sync2_q        <= sync1_q;
      pressed_prev_q <= pressed;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
`ifdef JUDGE_DEBOUNCE_EN
      logic [DCW-1:0] db_cnt_q;
      logic           db_lvl_q;
      // Count only while the synced level disagrees with the accepted one; any flip back restarts.
      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
          db_cnt_q <= '0;
          db_lvl_q <= 1'b0;
        end else if (~sync2_q[gi] != db_lvl_q) begin
          if (db_cnt_q == DB_LAST) begin
            db_cnt_q <= '0;
            db_lvl_q <= ~sync2_q[gi];
          end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
          end
        end else begin
          db_cnt_q <= '0;
        end
      end
      assign pressed[gi] = db_lvl_q;
`else
      assign pressed[gi] = ~sync2_q[gi];
`endif
    end
  endgenerate

  assign press_p = pressed & ~pressed_prev_q;
  assign rel_p   = ~pressed & pressed_prev_q;

  state_e           state_q, state_d;
  logic [LANES-1:0] lane_q, lane_d;
  logic [WCW-1:0]   win_cnt_q, win_cnt_d;
  logic [MCW-1:0]   miss_cnt_q, miss_cnt_d;
  logic             inc_q, inc_d, miss_q, miss_d;
  logic [MCW-1:0]   miss_cnt_inc;
  logic             limit_hit;
  logic             good_press;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      lane_q     <= '0;
      win_cnt_q  <= '0;
      miss_cnt_q <= '0;
      inc_q      <= 1'b0;
      miss_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      win_cnt_q  <= win_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      inc_q      <= inc_d;
      miss_q     <= miss_d;
    end
  end

  assign miss_cnt_inc = (miss_cnt_q == LIMIT) ? miss_cnt_q : miss_cnt_q + 1'b1;
  assign limit_hit    = (miss_cnt_inc == LIMIT);
  // Scores only a single-lane press on the latched lane with no other key held down.
  assign good_press   = (press_p == lane_q) && $onehot(press_p) && ((pressed & ~lane_q) == '0);

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    win_cnt_d  = win_cnt_q;
    miss_cnt_d = miss_cnt_q;
    inc_d      = 1'b0;
    miss_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!startn) begin
          state_d    = S_WAIT_TILE;
          miss_cnt_d = '0;
        end
      end
      S_WAIT_TILE: begin
        if (!startn) begin
          miss_cnt_d = '0;
        end else if (tile_arrive) begin
          lane_d    = tile_lane;
          win_cnt_d = WIN_LOAD;
          state_d   = S_WINDOW;
        end
      end
      S_WINDOW: begin
        if (!startn) begin
          state_d    = S_WAIT_TILE;
          miss_cnt_d = '0;
        end else if (tile_arrive) begin
          miss_d     = 1'b1;
          miss_cnt_d = miss_cnt_inc;
          lane_d     = tile_lane;
          win_cnt_d  = WIN_LOAD;
          state_d    = limit_hit ? S_OVER : S_WINDOW;
        end else if (good_press) begin
          inc_d   = 1'b1;
          state_d = S_HOLD;
        end else if ((|press_p) || (win_cnt_q == '0)) begin
          miss_d     = 1'b1;
          miss_cnt_d = miss_cnt_inc;
          state_d    = limit_hit ? S_OVER : S_WAIT_TILE;
        end else begin
          win_cnt_d = win_cnt_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (!startn) begin
          state_d    = S_WAIT_TILE;
          miss_cnt_d = '0;
        end else if ((rel_p & lane_q) != '0) begin
          inc_d   = 1'b1;
          state_d = S_WAIT_TILE;
        end else if (tile_arrive) begin
          inc_d     = 1'b1;
          lane_d    = tile_lane;
          win_cnt_d = WIN_LOAD;
          state_d   = S_WINDOW;
        end
      end
      S_OVER: begin
        if (!startn) begin
          state_d    = S_IDLE;
          miss_cnt_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    game_over = (state_q == S_OVER);
    lane_led  = ((state_q == S_WINDOW) || (state_q == S_HOLD)) ? lane_q : '0;
  end

  assign increment  = inc_q;
  assign miss       = miss_q;
  assign miss_count = miss_cnt_q;

endmodule
